rotate_scheduler: RTL and testbench

- Sequencing controller for the 3-position HEX rotation datapath: the char mux chain plus the 7-segment decoders.
- Generates the 2-bit rotation select consumed by the mux chain, at a programmable rate.
- Supports pause/run, forward/reverse direction, and debounced single-step from a push button.
- Replaces the free-running 25-bit counter in the display top level. Sits between board inputs (CLOCK_50, SW, KEY) and the mux select input.

---
 rtl/rot_pkg.sv | 28 ++
 rtl/step_debounce.sv | 67 ++++++
 rtl/rotate_scheduler.sv | 113 +++++++++++
 tb/tb_rotate_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the HEX rotation scheduler: controller state
// encoding, rotation limits, direction codes and the sel advance rule.
package rot_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'b00,
        ST_RUN   = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    localparam logic [1:0] SEL_MAX = 2'd2;
    localparam logic       DIR_FWD = 1'b0;
    localparam logic       DIR_REV = 1'b1;

    // Next rotation index; an out-of-range index restarts from position 0.
    function automatic logic [1:0] next_sel(input logic [1:0] cur, input logic dir_v);
        logic [1:0] base;
        base = (cur > SEL_MAX) ? 2'd0 : cur;
        if (dir_v == DIR_FWD) begin
            next_sel = (base == SEL_MAX) ? 2'd0 : base + 2'd1;
        end else if (dir_v == DIR_REV) begin
            next_sel = (base == 2'd0) ? SEL_MAX : base - 2'd1;
        end else begin
            next_sel = base;
        end
    endfunction

endpackage

// File: rtl/step_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a stable-level
// counter. step_clean_o is the accepted button level; step_flip_o is high in
// the cycle where the opposite level has been stable for DEB_CYCLES cycles, so
// step_clean_o toggles on the following edge. clr_i parks the conditioner in
// the released state with an empty count.
module step_debounce #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic step_i,
    input  logic clr_i,
    output logic step_clean_o,
    output logic step_flip_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

    logic [1:0]    sync_q;
    logic          step_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;

    assign step_s = sync_q[1];

    // Bring the raw, bouncy button level into the clock domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], step_i};
        end
    end

    // Count consecutive cycles disagreeing with the accepted level; flip it once the count is full.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (clr_i) begin
            cnt_d   = '0;
            clean_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            clean_d = ~clean_q;
        end else if (step_s != clean_q) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Debounce counter and accepted-level registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign step_clean_o = clean_q;
    assign step_flip_o  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/rotate_scheduler.sv
// Sequencing controller for the 3-position HEX rotation: produces the mux
// select at a programmable rate, with pause/run, direction control and a
// debounced single-step button.
module rotate_scheduler
    import rot_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 500_000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       run_en,
    input  logic       dir,
    input  logic       step,
    output logic [1:0] sel,
    output logic       tick,
    output logic [1:0] state
);

    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

    logic [1:0]    run_sync_q, dir_sync_q;
    logic          run_s, dir_s;
    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic          tick_q, tick_d;
    logic [DW-1:0] div_q, div_d;
    logic          advance;
    logic          step_clean, step_flip;

    assign run_s = run_sync_q[1];
    assign dir_s = dir_sync_q[1];

    // Synchronize the switch levels before any decision uses them.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            run_sync_q <= 2'b00;
            dir_sync_q <= 2'b00;
        end else begin
            run_sync_q <= {run_sync_q[0], run_en};
            dir_sync_q <= {dir_sync_q[0], dir};
        end
    end

    // The button is ignored while auto-rotating, so its conditioner is held clear in RUN.
    step_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_step_debounce (
        .clk_i        (CLOCK_50),
        .rst_ni       (resetn),
        .step_i       (step),
        .clr_i        (state_q == ST_RUN),
        .step_clean_o (step_clean),
        .step_flip_o  (step_flip)
    );

    // Next-state logic: run has priority over a step press, and leaving RUN drops the partial period.
    always_comb begin
        state_d = state_q;
        div_d   = '0;
        advance = 1'b0;
        unique case (state_q)
            ST_PAUSE: begin
                if (run_s) begin
                    state_d = ST_RUN;
                end else if (step_flip && !step_clean) begin
                    advance = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_RUN: begin
                if (!run_s) begin
                    state_d = ST_PAUSE;
                end else if (div_q == DIV_MAX) begin
                    advance = 1'b1;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            ST_HOLD: begin
                if (step_flip && step_clean) begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d = ST_PAUSE;
            end
        endcase
        sel_d  = advance ? next_sel(sel_q, dir_s) : sel_q;
        tick_d = advance;
    end

    // Controller state, divider, rotation index and tick registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_PAUSE;
            div_q   <= '0;
            sel_q   <= 2'd0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
        end
    end

    assign sel   = sel_q;
    assign tick  = tick_q;
    assign state = state_q;

endmodule

// File: tb/tb_rotate_scheduler.sv
// Self-checking bench for rotate_scheduler with TICK_DIV=4, DEB_CYCLES=3.
// A cycle-level behavioural model runs alongside the DUT and is compared on
// every falling edge; directed sequences add hand-computed literal checks.
module tb_rotate_scheduler;

    localparam int TD  = 4;
    localparam int DEB = 3;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       run_en;
    logic       dir;
    logic       step;
    logic [1:0] sel;
    logic       tick;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;

    rotate_scheduler #(
        .TICK_DIV   (TD),
        .DEB_CYCLES (DEB)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .run_en   (run_en),
        .dir      (dir),
        .step     (step),
        .sel      (sel),
        .tick     (tick),
        .state    (state)
    );

    // Behavioural model: 0 = pause, 1 = run, 2 = hold; sel kept as 0..2 modulo 3.
    int mState, mSel, mDiv, mCnt, mTick;
    int mRun1, mRun2, mDir1, mDir2, mStep1, mStep2;
    int nState, nDiv, nCnt, adv;

    // Model advances one clock per rising edge and clears on reset.
    always @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            mState = 0; mSel = 0; mDiv = 0; mCnt = 0; mTick = 0;
            mRun1 = 0; mRun2 = 0; mDir1 = 0; mDir2 = 0; mStep1 = 0; mStep2 = 0;
        end else begin
            nState = mState;
            nDiv   = 0;
            nCnt   = 0;
            adv    = 0;
            if (mState == 0) begin
                if (mRun2 == 1) nState = 1;
                else if (mCnt == DEB) begin adv = 1; nState = 2; end
                else nCnt = (mStep2 == 1) ? ((mCnt + 1 > DEB) ? DEB : mCnt + 1) : 0;
            end else if (mState == 1) begin
                if (mRun2 == 0) nState = 0;
                else if (mDiv == TD - 1) adv = 1;
                else nDiv = mDiv + 1;
            end else begin
                if (mCnt == DEB) nState = 0;
                else nCnt = (mStep2 == 0) ? ((mCnt + 1 > DEB) ? DEB : mCnt + 1) : 0;
            end
            if (nState != mState) nCnt = 0;
            if (adv == 1) mSel = (mDir2 == 0) ? (mSel + 1) % 3 : (mSel + 2) % 3;
            mTick  = adv;
            mState = nState;
            mDiv   = nDiv;
            mCnt   = nCnt;
            mRun2  = mRun1;  mRun1  = int'(run_en);
            mDir2  = mDir1;  mDir1  = int'(dir);
            mStep2 = mStep1; mStep1 = int'(step);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare the DUT against the model on every falling edge.
    always @(negedge CLOCK_50) begin
        if (checkEn) begin
            checkOutput("model sel", int'(sel), mSel);
            checkOutput("model tick", int'(tick), mTick);
            checkOutput("model state", int'(state), mState);
        end
    end

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic stepPat(input int i);
        if (i == 0 || i == 2 || (i >= 4 && i <= 13) || i == 15) return 1'b1;
        return 1'b0;
    endfunction

    int tickCount;
    int seen [4];

    initial begin
        resetn = 1'b0; run_en = 1'b0; dir = 1'b0; step = 1'b0;
        applyStimulus(3);
        checkOutput("reset sel", int'(sel), 0);
        checkOutput("reset tick", int'(tick), 0);
        checkOutput("reset state", int'(state), 0);
        resetn  = 1'b1;
        checkEn = 1'b1;

        // Run forward from reset.
        run_en = 1'b1;
        applyStimulus(2);
        checkOutput("still paused during sync", int'(state), 0);
        applyStimulus(1);
        checkOutput("run entered", int'(state), 1);
        tickCount = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1);
            if (tick) begin
                if (tickCount < 4) seen[tickCount] = int'(sel);
                tickCount++;
            end
        end
        checkOutput("run tick count", tickCount, 4);
        checkOutput("run seq 0", seen[0], 1);
        checkOutput("run seq 1", seen[1], 2);
        checkOutput("run seq 2", seen[2], 0);
        checkOutput("run seq 3", seen[3], 1);

        // Reverse direction, then switch back just before an advance.
        dir = 1'b1;
        applyStimulus(4);
        checkOutput("rev step 1", int'(sel), 0);
        checkOutput("rev tick", int'(tick), 1);
        applyStimulus(4);
        checkOutput("rev step 2", int'(sel), 2);
        applyStimulus(4);
        checkOutput("rev step 3", int'(sel), 1);
        applyStimulus(1);
        dir = 1'b0;
        applyStimulus(3);
        checkOutput("late dir change", int'(sel), 2);
        checkOutput("late dir tick", int'(tick), 1);

        // Pause mid-period discards the partial period.
        applyStimulus(8);
        checkOutput("pre-pause sel", int'(sel), 1);
        run_en = 1'b0;
        applyStimulus(3);
        checkOutput("paused state", int'(state), 0);
        checkOutput("paused sel", int'(sel), 1);
        applyStimulus(4);
        checkOutput("pause holds sel", int'(sel), 1);
        run_en = 1'b1;
        applyStimulus(6);
        checkOutput("no early advance", int'(sel), 1);
        applyStimulus(1);
        checkOutput("full period advance", int'(sel), 2);
        run_en = 1'b0;
        applyStimulus(3);
        checkOutput("paused for step", int'(state), 0);

        // Bouncy press, long hold, bouncy release: exactly one advance.
        tickCount = 0;
        for (int i = 0; i < 30; i++) begin
            step = stepPat(i);
            applyStimulus(1);
            if (tick) tickCount++;
            if (i + 1 == 9) begin
                checkOutput("press not yet accepted", int'(state), 0);
                checkOutput("press sel before", int'(sel), 2);
            end
            if (i + 1 == 10) begin
                checkOutput("press accepted state", int'(state), 2);
                checkOutput("press advance sel", int'(sel), 0);
                checkOutput("press tick", int'(tick), 1);
            end
            if (i + 1 == 21) checkOutput("still holding", int'(state), 2);
            if (i + 1 == 22) checkOutput("release accepted", int'(state), 0);
        end
        checkOutput("one tick per press", tickCount, 1);
        checkOutput("sel after press", int'(sel), 0);

        // Run request and qualified press together: run wins, press discarded.
        step = 1'b1;
        applyStimulus(3);
        run_en = 1'b1;
        applyStimulus(3);
        checkOutput("priority state", int'(state), 1);
        checkOutput("priority sel", int'(sel), 0);
        checkOutput("priority tick", int'(tick), 0);
        applyStimulus(3);
        checkOutput("step ignored in run", int'(sel), 0);
        applyStimulus(1);
        checkOutput("run advance with step", int'(sel), 1);
        applyStimulus(4);
        checkOutput("before reset sel", int'(sel), 2);

        // Asynchronous reset mid-period, checked before any clock edge.
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async reset sel", int'(sel), 0);
        checkOutput("async reset tick", int'(tick), 0);
        checkOutput("async reset state", int'(state), 0);
        step = 1'b0; run_en = 1'b0;
        applyStimulus(2);
        resetn = 1'b1;
        applyStimulus(4);
        checkOutput("idle after reset", int'(state), 0);

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
